// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the platform interrupt controller.
//   - register window offsets (relative to the controller base address)
//   - id_width(): width needed to encode source IDs 1..n plus 0 = none
//   - `Irq_base: default bus base address of the 256-byte window
`ifndef Irq_base
`define Irq_base 64'h0000_0000_2000_0000
`endif

package irq_pkg;

    localparam logic [7:0] OFF_ENABLE    = 8'h00;
    localparam logic [7:0] OFF_MODE      = 8'h08;
    localparam logic [7:0] OFF_PENDING   = 8'h10;
    localparam logic [7:0] OFF_THRESHOLD = 8'h18;
    localparam logic [7:0] OFF_CLAIM     = 8'h20;
    localparam logic [7:0] OFF_PRIO_BASE = 8'h40;
    localparam int         WIN_BYTES     = 256;

    function automatic int id_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// irq_prio_arb: combinational winner selection.
//   elig      : per-source eligibility (pending & enable & !in_service)
//   prio      : per-source priority
//   threshold : a source must have prio strictly above this to win
//   win_id    : winning ID (1..NUM_SRC), 0 when none
//   win_vld   : a winner exists
// Scanning upward with a strict '>' keeps the lowest ID on priority ties,
// and seeding the running best with threshold folds the threshold test
// (and the "priority 0 never delivered" rule) into the same compare.
module irq_prio_arb #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 4
) (
    input  logic [NUM_SRC-1:0]             elig,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]              threshold,
    output logic [ID_W-1:0]                win_id,
    output logic                           win_vld
);

    logic [PRIO_W-1:0] best;

    always_comb begin
        best    = threshold;
        win_id  = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (prio[i] > best)) begin
                best    = prio[i];
                win_id  = ID_W'(i + 1);
                win_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller in front of the core.
//   clk, reset (async, active-low)
//   irq_src      : raw asynchronous sources, bit i is ID i+1
//   irq_vector   : registered winning ID, 0 when irq_pending=0
//   irq_pending  : registered request to the core
//   irq_ack      : core took the interrupt (claims irq_vector)
//   irq_complete : core executed mret (completes active_id)
//   bus_*        : 64-bit load/store register window at BASE_ADDR
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter int          PRIO_W    = 3,
    parameter logic [63:0] BASE_ADDR = `Irq_base,
    localparam int         ID_W      = id_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [ID_W-1:0]    irq_vector,
    output logic               irq_pending,
    input  logic               irq_ack,
    input  logic               irq_complete,
    input  logic [63:0]        bus_address,
    input  logic [63:0]        bus_write_data,
    input  logic               bus_write_enable,
    input  logic               bus_read_enable,
    output logic [63:0]        bus_read_data
);

    logic [NUM_SRC-1:0]             s1, s2, s3;
    logic [NUM_SRC-1:0]             enable, mode, pending, in_service, in_service_nx;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]              threshold;
    logic [ID_W-1:0]                active_id, active_id_nx, win_id;
    logic                           win_vld;

    // ---- address decode ----
    logic [63:0]        off;
    logic [7:0]         reg_off;
    logic               in_win, claim_rd, claim_wr, w1c_wr, claim, complete;
    logic [NUM_SRC-1:0] prio_hit, rise;
    logic [63:0]        rd_val;

    assign off      = bus_address - BASE_ADDR;
    assign in_win   = (bus_address >= BASE_ADDR) && (off[63:8] == '0) && (off[2:0] == 3'b000);
    assign reg_off  = off[7:0];
    assign claim_rd = bus_read_enable  && in_win && (reg_off == OFF_CLAIM);
    assign claim_wr = bus_write_enable && in_win && (reg_off == OFF_CLAIM);
    assign w1c_wr   = bus_write_enable && in_win && (reg_off == OFF_PENDING);

    // PRIO slots that would fall past the 256-byte window are unreachable
    // rather than aliasing onto the low registers.
    always_comb begin
        prio_hit = '0;
        for (int i = 0; i < NUM_SRC; i++)
            prio_hit[i] = in_win && (int'(OFF_PRIO_BASE) + 8 * i < WIN_BYTES)
                          && (reg_off == OFF_PRIO_BASE + 8'(8 * i));
    end

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OFF_ENABLE:    rd_val = 64'(enable);
            OFF_MODE:      rd_val = 64'(mode);
            OFF_PENDING:   rd_val = 64'(pending);
            OFF_THRESHOLD: rd_val = 64'(threshold);
            OFF_CLAIM:     rd_val = 64'(irq_vector);
            default: begin
                for (int i = 0; i < NUM_SRC; i++)
                    if (prio_hit[i]) rd_val = 64'(prio[i]);
            end
        endcase
        if (!in_win) rd_val = '0;
    end

    // ---- claim / complete ----
    // Complete is applied before claim so both can land in one cycle.
    assign claim    = (irq_ack && irq_pending) || (claim_rd && (irq_vector != '0));
    assign complete = (active_id != '0) &&
                      (irq_complete || (claim_wr && (bus_write_data == 64'(active_id))));

    always_comb begin
        in_service_nx = in_service;
        active_id_nx  = active_id;
        if (complete) active_id_nx = '0;
        if (claim)    active_id_nx = irq_vector;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (complete && (active_id == ID_W'(i + 1))) in_service_nx[i] = 1'b0;
            if (claim && (irq_vector == ID_W'(i + 1)))   in_service_nx[i] = 1'b1;
        end
    end

    assign rise = s2 & ~s3;

    irq_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .elig      (pending & enable & ~in_service),
        .prio      (prio),
        .threshold (threshold),
        .win_id    (win_id),
        .win_vld   (win_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            enable        <= '0;
            mode          <= '0;
            pending       <= '0;
            prio          <= '0;
            threshold     <= '0;
            in_service    <= '0;
            active_id     <= '0;
            irq_pending   <= 1'b0;
            irq_vector    <= '0;
            bus_read_data <= '0;
        end else begin
            s1 <= irq_src;
            s2 <= s1;
            s3 <= s2;

            if (bus_write_enable && in_win && (reg_off == OFF_ENABLE))
                enable <= bus_write_data[NUM_SRC-1:0];
            if (bus_write_enable && in_win && (reg_off == OFF_MODE))
                mode <= bus_write_data[NUM_SRC-1:0];
            if (bus_write_enable && in_win && (reg_off == OFF_THRESHOLD))
                threshold <= bus_write_data[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++)
                if (bus_write_enable && prio_hit[i]) prio[i] <= bus_write_data[PRIO_W-1:0];

            // Edge sources latch; a new edge beats W1C and claim clearing.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!mode[i])
                    pending[i] <= s2[i];
                else if (rise[i])
                    pending[i] <= 1'b1;
                else if ((w1c_wr && bus_write_data[i]) || (claim && (irq_vector == ID_W'(i + 1))))
                    pending[i] <= 1'b0;
            end

            in_service <= in_service_nx;
            active_id  <= active_id_nx;

            // No nesting: nothing is presented while anything is in service.
            irq_pending   <= win_vld && (in_service_nx == '0);
            irq_vector    <= (win_vld && (in_service_nx == '0)) ? win_id : '0;
            bus_read_data <= bus_read_enable ? rd_val : '0;
        end
    end

endmodule
